// File: rtl/alu32_rr_arbiter.sv
// One alu32 shared by NUM_REQ requesters: round-robin grant, one issue per cycle,
// single registered response slot with downstream backpressure.

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        err
);
  logic [32:0] add_w;
  logic [32:0] sub_w;

  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = {1'b0, a} + {1'b0, ~b} + 33'd1;
    result = '0;
    cout   = 1'b0;
    err    = 1'b0;
    case (op)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: begin result = add_w[31:0]; cout = add_w[32]; end
      4'b0110: begin result = sub_w[31:0]; cout = sub_w[32]; end
      // SLT reports the carry of the underlying subtraction
      4'b0111: begin result = {31'd0, $signed(a) < $signed(b)}; cout = sub_w[32]; end
      4'b1100: result = ~(a | b);
      default: err = 1'b1;
    endcase
    zero = (result == 32'd0);
  end
endmodule

// Per-requester grant: this lane wins if it is valid and no valid lane sits
// closer to ptr in the circular scan order.
module alu32_rr_lane #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int IDX     = 0
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               can_issue,
  output logic               grant
);
  int   my_d;
  int   d;
  logic blocked;

  always_comb begin
    my_d    = IDX - int'(ptr);
    if (my_d < 0) my_d = my_d + NUM_REQ;
    d       = 0;
    blocked = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = j - int'(ptr);
      if (d < 0) d = d + NUM_REQ;
      if (valid[j] && (d < my_d)) blocked = 1'b1;
    end
    grant = can_issue && valid[IDX] && !blocked;
  end
endmodule

module alu32_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_a,
  input  logic [NUM_REQ-1:0][31:0]  req_b,
  input  logic [NUM_REQ-1:0][3:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [31:0]               rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_cout,
  output logic                      rsp_err
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     result;
    logic            zero;
    logic            cout;
    logic            err;
  } rsp_t;

  slot_e            state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  rsp_t             rsp_q, rsp_d;

  logic [NUM_REQ-1:0] grant;
  logic               can_issue;
  logic               any_grant;
  logic [ID_W-1:0]    g_idx;
  logic [31:0]        alu_a, alu_b, alu_res;
  logic [3:0]         alu_op;
  logic               alu_zero, alu_cout, alu_err;

  // Reset blocks grants so nothing handshakes while state is being cleared
  assign can_issue = !rst && ((state_q == EMPTY) || rsp_ready);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    alu32_rr_lane #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .IDX(i)) u_lane (
      .valid     (req_valid),
      .ptr       (ptr_q),
      .can_issue (can_issue),
      .grant     (grant[i])
    );
  end

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) g_idx = ID_W'(i);
  end

  assign alu_a  = req_a[g_idx];
  assign alu_b  = req_b[g_idx];
  assign alu_op = req_op[g_idx];

  alu32 u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero),
    .cout   (alu_cout),
    .err    (alu_err)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rsp_d   = rsp_q;
    case (state_q)
      EMPTY: if (any_grant) state_d = FULL;
      FULL:  if (!any_grant && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (any_grant) begin
      rsp_d.id     = g_idx;
      rsp_d.result = alu_res;
      rsp_d.zero   = alu_zero;
      rsp_d.cout   = alu_cout;
      rsp_d.err    = alu_err;
      ptr_d        = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_zero   = rsp_q.zero;
  assign rsp_cout   = rsp_q.cout;
  assign rsp_err    = rsp_q.err;
endmodule

// File: tb/tb_alu32_rr_arbiter.sv
// Bench for alu32_rr_arbiter (4 requesters): directed scenarios plus random
// traffic, all checked every cycle against a behavioural slot/pointer model.

module tb_alu32_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid, req_ready;
  logic [N-1:0][31:0]  req_a, req_b;
  logic [N-1:0][3:0]   req_op;
  logic                rsp_valid, rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_zero, rsp_cout, rsp_err;

  alu32_rr_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: one response slot plus the round-robin pointer
  bit          m_valid = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_res   = '0;
  bit          m_zero  = 1'b0, m_cout = 1'b0, m_err = 1'b0;
  int          m_ptr   = 0;
  int          m_last_gnt = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [31:0] r, output bit c, output bit e);
    r = '0; c = 1'b0; e = 1'b0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin r = a + b; c = ({32'd0, a} + {32'd0, b}) >= 64'h1_0000_0000; end
      4'h6: begin r = a - b; c = (a >= b); end
      4'h7: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = (a >= b); end
      4'hC: r = ~(a | b);
      default: e = 1'b1;
    endcase
  endtask

  // model update on every rising edge
  initial forever begin
    int g;
    logic [31:0] r;
    bit c, e;
    @(posedge clk);
    g = exp_grant();
    m_last_gnt = g;
    if (rst) begin
      m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_cout = 0; m_err = 0; m_ptr = 0;
    end else if (g >= 0) begin
      ref_alu(req_a[g], req_b[g], req_op[g], r, c, e);
      m_valid = 1; m_id = g; m_res = r; m_zero = (r == 0); m_cout = c; m_err = e;
      m_ptr = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
  end

  // compare process: every falling edge
  initial forever begin
    int g;
    @(negedge clk);
    g = exp_grant();
    chk("req_ready", {28'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_id", {30'd0, rsp_id}, m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
    chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, m_cout});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] OPS [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

  initial begin
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'(i * 16); req_b[i] = 32'd1; req_op[i] = 4'h2;
    end
    // reset held two edges with everyone requesting
    tick();
    @(negedge clk);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant", {28'd0, req_ready}, 32'h1);

    // round robin with all valid
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rr_id", {30'd0, rsp_id}, 32'(c % 4));
      chk("rr_result", rsp_result, 32'((c % 4) * 16 + 1));
    end
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // single ADD with carry-out
    tick();
    req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1; req_op[1] = 4'h2; req_valid = 4'b0010;
    @(negedge clk);
    chk("add_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = '0; rsp_ready = 1'b0;
    req_a[0] = 32'hF0F0_F0F0; req_b[0] = 32'hFFFF_0000; req_op[0] = 4'h0; req_valid = 4'b0001;
    @(negedge clk);
    chk("add_id", {30'd0, rsp_id}, 32'd1);
    chk("add_result", rsp_result, 32'd0);
    chk("add_zero", {31'd0, rsp_zero}, 32'd1);
    chk("add_cout", {31'd0, rsp_cout}, 32'd1);

    // backpressure: slot full, req0 waiting
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {28'd0, req_ready}, 32'h1);
    tick();
    req_a[2] = 32'hFFFF_FFFB; req_b[2] = 32'd3; req_op[2] = 4'h7; req_valid = 4'b0100;
    @(negedge clk);
    chk("and_id", {30'd0, rsp_id}, 32'd0);
    chk("and_result", rsp_result, 32'hF0F0_0000);

    // SLT then SUB of -5 and 3
    tick();
    req_op[2] = 4'h6;
    @(negedge clk);
    chk("slt_result", rsp_result, 32'd1);
    tick();
    req_op[0] = 4'hF; req_valid = 4'b0001;
    @(negedge clk);
    chk("sub_result", rsp_result, 32'hFFFF_FFF8);
    chk("sub_zero", {31'd0, rsp_zero}, 32'd0);

    // illegal opcode, then reset while full and stalled
    tick();
    req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("ill_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_zero", {31'd0, rsp_zero}, 32'd1);
    chk("ill_cout", {31'd0, rsp_cout}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_err", {31'd0, rsp_err}, 32'd0);

    // random traffic; requesters hold their op until handshaken
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_last_gnt == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[i]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          req_b[i]  = ($urandom_range(0, 7) == 0) ? req_a[i] : $urandom;
          req_op[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : OPS[$urandom_range(0, 5)];
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
